// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants.
package instr_fetch_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t IFU_NOP_INSTR = 32'h0000_0013;
   localparam word_t PC_INC        = 32'd4;

   typedef struct packed {
      logic  fault;
      word_t pc;
      word_t instr;
   } if_entry_t;

   function automatic word_t align_pc(input word_t a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO for fetched entries, with flush.
module ifu_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  if_entry_t                  wdata,
   input  logic                       pop,
   output if_entry_t                  rdata,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   if_entry_t     mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push_en;
   logic          pop_en;

   assign valid   = (count != '0);
   assign push_en = push & ~flush;
   assign pop_en  = pop & valid & ~flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // a full buffer may only accept a word in the same cycle it pops one
   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst)
      (push_en & ~pop_en) |-> (count != CW'(DEPTH))
   );

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, bus credit, in-flight tracking and redirect discard.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ready,
   input  logic        ibus_rvalid,
   input  logic [31:0] ibus_rdata,
   input  logic        ibus_err,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_fault
);

   localparam int         CW      = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   word_t         fetch_pc;
   word_t         resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   inflight;
   logic          credit;
   logic          accept;
   logic          drop;
   logic          push;
   logic          pop;
   if_entry_t     push_data;
   if_entry_t     head;

   // a popped entry is not credited until the next cycle
   assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
   assign credit    = inflight < DEPTH_C;
   assign ibus_req  = ~rst & ~redirect & credit;
   assign ibus_addr = fetch_pc;
   assign accept    = ibus_req & ibus_ready;
   assign drop      = ibus_rvalid & (discard != '0);
   assign push      = ibus_rvalid & ~drop & ~redirect;
   assign pop       = if_valid & if_ready;

   always_comb begin
      push_data.fault = ibus_err;
      push_data.pc    = resp_pc;
      push_data.instr = ibus_err ? IFU_NOP_INSTR : ibus_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CW'(accept) - CW'(ibus_rvalid);
         if (redirect) begin
            fetch_pc <= align_pc(redirect_pc);
            resp_pc  <= align_pc(redirect_pc);
            // every read still on the bus belongs to the old path
            discard  <= outstanding - CW'(ibus_rvalid);
         end else begin
            if (accept) fetch_pc <= fetch_pc + PC_INC;
            if (push)   resp_pc  <= resp_pc + PC_INC;
            if (drop)   discard  <= discard - CW'(1);
         end
      end
   end

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (head),
      .valid (if_valid),
      .count (fifo_count)
   );

   assign if_instr = head.instr;
   assign if_pc    = head.pc;
   assign if_fault = head.fault;

   a_no_underflow: assert property (
      @(posedge clk) disable iff (rst)
      ibus_rvalid |-> (outstanding != '0)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: bus model, directed step table, scoreboard, random phase.
module tb_instr_fetch;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ready = 1'b0;
   logic        ibus_rvalid = 1'b0;
   logic [31:0] ibus_rdata = 32'h0;
   logic        ibus_err = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;

   instr_fetch #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ibus_req    (ibus_req),
      .ibus_addr   (ibus_addr),
      .ibus_ready  (ibus_ready),
      .ibus_rvalid (ibus_rvalid),
      .ibus_rdata  (ibus_rdata),
      .ibus_err    (ibus_err),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_fault    (if_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          cyc;
   } rd_t;

   typedef struct {
      int          ncyc;
      int          bus;
      bit          rsp0;
      int          rsp;
      int          ifr;
      bit          redir;
      logic [31:0] tgt;
      bit          chk;
      logic [31:0] exp_pc;
   } step_t;

   ent_t        sb[$];
   ent_t        dq[$];
   rd_t         pend[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          bus_pct = 100;
   int          rsp_pct = 100;
   int          ifr_pct = 100;
   logic [31:0] fetch_exp = RST_PC;
   step_t       steps[16];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic bit err_of(input logic [31:0] a);
      return a[7:0] == 8'h10;
   endfunction

   function automatic bit roll(input int pct);
      return int'($urandom % 100) < pct;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // one clock: called and returns at a falling edge
   task automatic tick(input bit redir, input logic [31:0] tgt,
                       input bit rsp_ok);
      rd_t  rp;
      rd_t  nr;
      ent_t e;
      bit   rv;
      bit   req_exp;
      rv          = 1'b0;
      ibus_ready  = roll(bus_pct);
      if_ready    = roll(ifr_pct);
      redirect    = redir;
      redirect_pc = tgt;
      ibus_err    = 1'b0;
      ibus_rdata  = 32'h0;
      if (rsp_ok && pend.size() != 0) begin
         if (pend[0].cyc < cyc && roll(rsp_pct)) begin
            rv = 1'b1;
            ibus_err   = err_of(pend[0].addr);
            ibus_rdata = ibus_err ? 32'hDEAD_BEEF
                                  : instr_of(pend[0].addr);
         end
      end
      ibus_rvalid = rv;
      #1;
      req_exp = !redir && (pend.size() + sb.size() < DEPTH);
      chk("ibus_req", 32'(ibus_req), 32'(req_exp));
      if (ibus_req && req_exp) chk("ibus_addr", ibus_addr, fetch_exp);
      chk("if_valid", 32'(if_valid), 32'(sb.size() != 0));
      if (if_valid && sb.size() != 0) begin
         chk("if_pc", if_pc, sb[0].pc);
         chk("if_instr", if_instr, sb[0].instr);
         chk("if_fault", 32'(if_fault), 32'(sb[0].fault));
      end
      if (rv) rp = pend.pop_front();
      if (redir) begin
         sb.delete();
         epoch++;
         fetch_exp = {tgt[31:2], 2'b00};
      end else begin
         if (if_valid && if_ready) begin
            e.instr = if_instr;
            e.pc    = if_pc;
            e.fault = if_fault;
            dq.push_back(e);
            if (sb.size() != 0) void'(sb.pop_front());
         end
         if (rv && rp.ep == epoch) begin
            e.pc    = rp.addr;
            e.fault = err_of(rp.addr);
            e.instr = e.fault ? 32'h0000_0013 : instr_of(rp.addr);
            sb.push_back(e);
         end
      end
      if (ibus_req && ibus_ready) begin
         nr.addr = fetch_exp;
         nr.ep   = epoch;
         nr.cyc  = cyc;
         pend.push_back(nr);
         fetch_exp += 32'd4;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input bit mid);
      rst         = 1'b1;
      redirect    = 1'b0;
      ibus_rvalid = 1'b0;
      ibus_ready  = 1'b0;
      ibus_err    = 1'b0;
      if_ready    = 1'b0;
      #1;
      if (mid) begin
         chk("rst_async_if_valid", 32'(if_valid), 32'h0);
         chk("rst_async_ibus_req", 32'(ibus_req), 32'h0);
      end
      repeat (2) @(negedge clk);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_ibus_req", 32'(ibus_req), 32'h0);
      chk("rst_if_fault", 32'(if_fault), 32'h0);
      pend.delete();
      sb.delete();
      epoch++;
      fetch_exp = RST_PC;
      rst = 1'b0;
   endtask

   task automatic run_step(input step_t s, input int idx);
      bus_pct = s.bus;
      rsp_pct = s.rsp;
      ifr_pct = s.ifr;
      dq.delete();
      for (int i = 0; i < s.ncyc; i++)
         tick(s.redir && i == 0, s.tgt, (i == 0) ? s.rsp0 : 1'b1);
      if (s.chk) begin
         if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step%0d_first_pc: nothing delivered, want %h",
                     idx, s.exp_pc);
         end else begin
            chk($sformatf("step%0d_first_pc", idx), dq[0].pc, s.exp_pc);
         end
      end
   endtask

   task automatic expect_dq(input string name, input int idx,
                            input logic [31:0] pc, input logic fault,
                            input logic [31:0] instr);
      if (dq.size() <= idx) begin
         checks++;
         errors++;
         $display("FAIL %s: only %0d delivered, want pc %h",
                  name, dq.size(), pc);
      end else begin
         chk({name, "_pc"}, dq[idx].pc, pc);
         chk({name, "_fault"}, 32'(dq[idx].fault), 32'(fault));
         chk({name, "_instr"}, dq[idx].instr, instr);
      end
   endtask

   task automatic full_speed();
      bus_pct = 100;
      rsp_pct = 100;
      ifr_pct = 100;
      dq.delete();
   endtask

   initial begin
      //          ncyc bus rsp0 rsp ifr redir tgt            chk exp_pc
      steps[0]  = '{24, 100, 1, 100, 100, 0, 32'h0,         1, 32'h0};
      steps[1]  = '{10, 100, 1, 100,   0, 0, 32'h0,         0, 32'h0};
      steps[2]  = '{12, 100, 1, 100, 100, 0, 32'h0,         0, 32'h0};
      steps[3]  = '{ 6,   0, 1, 100, 100, 0, 32'h0,         0, 32'h0};
      steps[4]  = '{ 4, 100, 1,   0, 100, 1, 32'h8,         0, 32'h0};
      steps[5]  = '{10, 100, 0, 100, 100, 1, 32'h100,       1, 32'h100};
      steps[6]  = '{ 6,   0, 1, 100, 100, 0, 32'h0,         0, 32'h0};
      steps[7]  = '{ 4, 100, 1,   0, 100, 1, 32'h8,         0, 32'h0};
      steps[8]  = '{10, 100, 1, 100, 100, 1, 32'h100,       1, 32'h100};
      steps[9]  = '{10, 100, 1, 100, 100, 1, 32'h203,       1, 32'h200};
      steps[10] = '{ 6,   0, 1, 100, 100, 0, 32'h0,         0, 32'h0};
      steps[11] = '{ 3, 100, 1,   0, 100, 1, 32'h300,       0, 32'h0};
      steps[12] = '{ 1, 100, 0,   0, 100, 1, 32'h40,        0, 32'h0};
      steps[13] = '{10, 100, 1, 100, 100, 1, 32'h80,        1, 32'h80};
      steps[14] = '{10, 100, 1, 100, 100, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8};
      steps[15] = '{40,  60, 1,  70,  50, 0, 32'h0,         0, 32'h0};

      @(negedge clk);
      do_reset(1'b0);
      for (int i = 0; i < 16; i++) run_step(steps[i], i);

      full_speed();
      tick(1'b1, 32'h10, 1'b1);
      repeat (12) tick(1'b0, 32'h0, 1'b1);
      expect_dq("fault0", 0, 32'h10, 1'b1, 32'h0000_0013);
      expect_dq("fault1", 1, 32'h14, 1'b0, instr_of(32'h14));

      full_speed();
      tick(1'b1, 32'hFFFF_FFF8, 1'b1);
      repeat (12) tick(1'b0, 32'h0, 1'b1);
      expect_dq("wrap", 2, 32'h0, 1'b0, instr_of(32'h0));

      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            bus_pct = $urandom_range(100, 30);
            rsp_pct = $urandom_range(100, 30);
            ifr_pct = $urandom_range(100, 20);
         end
         if (i == 1500) do_reset(1'b1);
         if (roll(4))
            tick(1'b1, roll(20) ? (32'hFFFF_FFF0 | ($urandom & 32'h3))
                                : $urandom, 1'b1);
         else
            tick(1'b0, 32'h0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
